// File: rtl/retire_pkg.sv
// Shared types for the retire trace buffer: record kinds, record layout and drain FSM states.
// Classification priority lives here so the buffer and any consumer agree on kind meaning.
package retire_pkg;
  localparam int PC_W   = 16;
  localparam int INST_W = 16;
  localparam int REG_W  = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 32;

  typedef enum logic [2:0] {
    KIND_NOP    = 3'd0,
    KIND_REG_ST = 3'd1,
    KIND_REG_LD = 3'd2,
    KIND_REG    = 3'd3,
    KIND_HALT   = 3'd4,
    KIND_ST     = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    kind_e             kind;
    logic [CNT_W-1:0]  inum;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  // Register-write combinations outrank halt, which outranks a bare store.
  function automatic kind_e classify(input logic reg_wr, input logic mem_rd,
                                     input logic mem_wr, input logic halt);
    if (reg_wr && mem_wr) return KIND_REG_ST;
    if (reg_wr && mem_rd) return KIND_REG_LD;
    if (reg_wr)           return KIND_REG;
    if (halt)             return KIND_HALT;
    if (mem_wr)           return KIND_ST;
    return KIND_NOP;
  endfunction
endpackage

// File: rtl/retire_fifo.sv
// Record FIFO: write on push, head visible combinationally, pop advances next cycle.
// Push is ignored while full and pop while empty; storage is never cleared by reset.
module retire_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign push_ok  = push && (count_q != CW'(DEPTH));
  assign pop_ok   = pop && (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// File: rtl/retire_trace_buf.sv
// Classifies retiring instructions into trace records, numbers them and queues them for a consumer.
// Record visible the cycle after enqueue; stall while full; HALT drains the queue then raises done.
module retire_trace_buf
  import retire_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ret_valid,
  input  logic [15:0] ret_pc,
  input  logic [15:0] ret_inst,
  input  logic        reg_wr,
  input  logic [2:0]  wr_reg,
  input  logic [15:0] wr_data,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        halt,
  output logic        stall,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [2:0]  rec_kind,
  output logic [31:0] rec_inum,
  output logic [15:0] rec_pc,
  output logic [15:0] rec_inst,
  output logic [2:0]  rec_reg,
  output logic [15:0] rec_rdata,
  output logic [15:0] rec_addr,
  output logic [15:0] rec_mdata,
  output logic [31:0] cycle_count,
  output logic [31:0] inst_count,
  output logic        done
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [31:0]   cyc_q, cyc_d, inum_q, inum_d;
  logic [CW-1:0] occ;
  logic          enq, deq;
  rec_t          in_rec, head_rec;

  assign stall     = (occ == CW'(DEPTH));
  assign rec_valid = (occ != '0);
  assign enq       = ret_valid && !stall && (state_q == ST_RUN);
  assign deq       = rec_valid && rec_ready;

  always_comb begin
    in_rec       = '0;
    in_rec.kind  = classify(reg_wr, mem_rd, mem_wr, halt);
    in_rec.inum  = inum_q;
    in_rec.pc    = ret_pc;
    in_rec.inst  = ret_inst;
    in_rec.rg    = wr_reg;
    in_rec.rdata = wr_data;
    in_rec.addr  = mem_addr;
    in_rec.mdata = mem_data;
  end

  retire_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (enq),
    .push_dat (in_rec),
    .pop      (deq),
    .head_dat (head_rec),
    .count    (occ)
  );

  assign rec_kind    = head_rec.kind;
  assign rec_inum    = head_rec.inum;
  assign rec_pc      = head_rec.pc;
  assign rec_inst    = head_rec.inst;
  assign rec_reg     = head_rec.rg;
  assign rec_rdata   = head_rec.rdata;
  assign rec_addr    = head_rec.addr;
  assign rec_mdata   = head_rec.mdata;
  assign cycle_count = cyc_q;
  assign inst_count  = inum_q;
  assign done        = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    inum_d  = inum_q;
    if (state_q != ST_DONE) cyc_d = cyc_q + 32'd1;
    if (enq)                inum_d = inum_q + 32'd1;
    case (state_q)
      ST_RUN:   if (enq && in_rec.kind == KIND_HALT) state_d = ST_DRAIN;
      // Done once the last queued record (the HALT itself) leaves.
      ST_DRAIN: if (occ == '0 || (occ == CW'(1) && deq)) state_d = ST_DONE;
      default:  state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cyc_q   <= '0;
      inum_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      inum_q  <= inum_d;
    end
  end
endmodule

// File: tb/tb_retire_trace_buf.sv
// Randomized and directed stimulus for retire_trace_buf, checked every cycle against a queue model.
module tb_retire_trace_buf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ret_valid = 1'b0;
  logic [15:0] ret_pc = '0, ret_inst = '0, wr_data = '0, mem_addr = '0, mem_data = '0;
  logic        reg_wr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, halt = 1'b0, rec_ready = 1'b0;
  logic [2:0]  wr_reg = '0;
  logic        stall, rec_valid, done;
  logic [2:0]  rec_kind, rec_reg;
  logic [31:0] rec_inum, cycle_count, inst_count;
  logic [15:0] rec_pc, rec_inst, rec_rdata, rec_addr, rec_mdata;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  retire_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt), .stall(stall),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_inum(rec_inum),
    .rec_pc(rec_pc), .rec_inst(rec_inst), .rec_reg(rec_reg), .rec_rdata(rec_rdata),
    .rec_addr(rec_addr), .rec_mdata(rec_mdata), .cycle_count(cycle_count),
    .inst_count(inst_count), .done(done)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc, inst, rdata, addr, mdata;
    logic [2:0]  rg;
  } mrec_t;

  mrec_t       mq[$];
  int          m_state;  // 0 running, 1 draining, 2 finished
  logic [31:0] m_cyc, m_inst;

  function automatic logic [2:0] model_kind();
    if (reg_wr && mem_wr) return 3'd1;
    if (reg_wr && mem_rd) return 3'd2;
    if (reg_wr)           return 3'd3;
    if (halt)             return 3'd4;
    if (mem_wr)           return 3'd5;
    return 3'd0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_state = 0;
      m_cyc   = 0;
      m_inst  = 0;
    end else begin
      automatic int    old = m_state;
      automatic bit    full = (mq.size() == DEPTH);
      automatic bit    pop  = (mq.size() != 0) && rec_ready;
      automatic bit    enq  = ret_valid && !full && (m_state == 0);
      automatic mrec_t r;
      if (m_state != 2) m_cyc = m_cyc + 1;
      if (pop) void'(mq.pop_front());
      if (enq) begin
        r.kind = model_kind(); r.inum = m_inst; r.pc = ret_pc; r.inst = ret_inst;
        r.rg = wr_reg; r.rdata = wr_data; r.addr = mem_addr; r.mdata = mem_data;
        mq.push_back(r);
        m_inst = m_inst + 1;
      end
      if (old == 0 && enq && r.kind == 3'd4) m_state = 1;
      else if (old == 1 && mq.size() == 0)   m_state = 2;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", {31'd0, stall}, {31'd0, mq.size() == DEPTH});
      chk("m_rec_valid", {31'd0, rec_valid}, {31'd0, mq.size() != 0});
      chk("m_done", {31'd0, done}, {31'd0, m_state == 2});
      chk("m_cycle_count", cycle_count, m_cyc);
      chk("m_inst_count", inst_count, m_inst);
      if (mq.size() != 0) begin
        chk("m_kind", {29'd0, rec_kind}, {29'd0, mq[0].kind});
        chk("m_inum", rec_inum, mq[0].inum);
        chk("m_pc", {16'd0, rec_pc}, {16'd0, mq[0].pc});
        chk("m_inst", {16'd0, rec_inst}, {16'd0, mq[0].inst});
        chk("m_reg", {29'd0, rec_reg}, {29'd0, mq[0].rg});
        chk("m_rdata", {16'd0, rec_rdata}, {16'd0, mq[0].rdata});
        chk("m_addr", {16'd0, rec_addr}, {16'd0, mq[0].addr});
        chk("m_mdata", {16'd0, rec_mdata}, {16'd0, mq[0].mdata});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ins();
    ret_valid = 0; reg_wr = 0; mem_rd = 0; mem_wr = 0; halt = 0;
    ret_pc = '0; ret_inst = '0; wr_reg = '0; wr_data = '0; mem_addr = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    clear_ins();
    rst = 0;
    cyc();
    cyc();
    rst = 1;
  endtask

  task automatic nop(input logic [15:0] pc);
    clear_ins();
    ret_valid = 1; ret_pc = pc; ret_inst = pc ^ 16'h5A5A;
  endtask

  initial begin
    rec_ready = 0;
    do_reset();
    chk_en = 1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rec_valid", {31'd0, rec_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_inst", inst_count, 32'd0);

    // First register-write retire
    clear_ins();
    ret_valid = 1; reg_wr = 1; wr_reg = 3'd3; wr_data = 16'h00AB; ret_pc = 16'h0002; rec_ready = 1;
    cyc();
    chk("first_valid", {31'd0, rec_valid}, 32'd1);
    chk("first_kind", {29'd0, rec_kind}, 32'd3);
    chk("first_inum", rec_inum, 32'd0);
    chk("first_reg", {29'd0, rec_reg}, 32'd3);
    chk("first_rdata", {16'd0, rec_rdata}, 32'h00AB);
    chk("first_icount", inst_count, 32'd1);
    clear_ins();
    cyc();

    // Store kinds
    do_reset();
    rec_ready = 0;
    clear_ins();
    ret_valid = 1; mem_wr = 1; mem_addr = 16'h0100; mem_data = 16'h1234; ret_pc = 16'h0010;
    cyc();
    chk("st_kind", {29'd0, rec_kind}, 32'd5);
    chk("st_addr", {16'd0, rec_addr}, 32'h0100);
    chk("st_mdata", {16'd0, rec_mdata}, 32'h1234);
    reg_wr = 1;
    cyc();
    clear_ins();
    rec_ready = 1;
    cyc();
    chk("regst_kind", {29'd0, rec_kind}, 32'd1);
    ret_valid = 1; reg_wr = 1; mem_rd = 1;
    cyc();
    chk("regld_kind", {29'd0, rec_kind}, 32'd2);
    clear_ins();
    cyc();

    // Full FIFO, held fifth retire
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 4; i++) begin
      nop(16'(i));
      cyc();
    end
    chk("full_stall", {31'd0, stall}, 32'd1);
    chk("full_icount", inst_count, 32'd4);
    nop(16'd4);
    cyc();
    cyc();
    chk("held_stall", {31'd0, stall}, 32'd1);
    chk("held_icount", inst_count, 32'd4);
    chk("held_head", rec_inum, 32'd0);
    rec_ready = 1;
    cyc();
    chk("pop0_head", rec_inum, 32'd1);
    chk("pop0_icount", inst_count, 32'd4);
    cyc();
    chk("enq4_head", rec_inum, 32'd2);
    chk("enq4_icount", inst_count, 32'd5);
    clear_ins();
    cyc();
    chk("pop2_head", rec_inum, 32'd3);
    cyc();
    chk("pop3_head", rec_inum, 32'd4);
    chk("pop3_pc", {16'd0, rec_pc}, 32'd4);
    cyc();
    chk("drained_valid", {31'd0, rec_valid}, 32'd0);

    // HALT at inum 7 with two records queued
    do_reset();
    rec_ready = 1;
    for (int i = 0; i < 6; i++) begin
      nop(16'(16'h0100 + i));
      cyc();
    end
    rec_ready = 0;
    nop(16'h0106);
    cyc();
    nop(16'h0107);
    halt = 1;
    cyc();
    chk("halt_head", rec_inum, 32'd5);
    chk("halt_icount", inst_count, 32'd8);
    nop(16'h0108);
    cyc(); cyc(); cyc();
    chk("drain_icount", inst_count, 32'd8);
    chk("drain_done", {31'd0, done}, 32'd0);
    rec_ready = 1;
    cyc();
    cyc();
    chk("drain2_done", {31'd0, done}, 32'd0);
    cyc();
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_empty", {31'd0, rec_valid}, 32'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk("done_held", {31'd0, done}, 32'd1);
    chk("done_icount", inst_count, 32'd8);

    // Reset mid-run with three queued
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 3; i++) begin
      nop(16'(16'h0200 + i));
      cyc();
    end
    rst = 0;
    cyc();
    chk("mid_rst_valid", {31'd0, rec_valid}, 32'd0);
    chk("mid_rst_cycle", cycle_count, 32'd0);
    chk("mid_rst_inst", inst_count, 32'd0);
    rst = 1;
    clear_ins();
    cyc();
    chk("after_rst_cycle", cycle_count, 32'd1);
    chk("after_rst_valid", {31'd0, rec_valid}, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      ret_valid = ($urandom_range(0, 3) != 0);
      reg_wr    = $urandom_range(0, 1);
      mem_rd    = $urandom_range(0, 1);
      mem_wr    = $urandom_range(0, 1);
      halt      = ($urandom_range(0, 39) == 0);
      ret_pc    = 16'($urandom);
      ret_inst  = 16'($urandom);
      wr_reg    = 3'($urandom);
      wr_data   = 16'($urandom);
      mem_addr  = 16'($urandom);
      mem_data  = 16'($urandom);
      rec_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 299) != 0);
      if (m_state == 2 && $urandom_range(0, 7) == 0) rst = 0;
      cyc();
    end

    clear_ins();
    rst = 1;
    cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
